// File: rtl/tt_um_sv_uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even parity, one stop bit.
// The frame starts on a rising edge of uio_in[0]; a request edge seen while busy sets a sticky overrun flag.
module tt_um_sv_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

   state_t     state, state_next;
   logic [7:0] baud_cnt, baud_next;
   logic [2:0] bit_idx, bit_next;
   logic [7:0] shreg, shreg_next;
   logic       par_en, par_en_next;
   logic       par_bit, par_bit_next;
   logic [6:0] frame_count, count_next;
   logic       overrun, overrun_next;
   logic       send_q;
   logic       send_edge;
   logic       bit_done;
   logic       tx;
   logic       busy;
   logic       unused;

   assign send_edge = uio_in[0] & ~send_q;
   assign bit_done  = (baud_cnt == BAUD_LAST);
   assign unused    = &{1'b0, ena, uio_in[7:2]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         baud_cnt    <= 8'd0;
         bit_idx     <= 3'd0;
         shreg       <= 8'd0;
         par_en      <= 1'b0;
         par_bit     <= 1'b0;
         frame_count <= 7'd0;
         overrun     <= 1'b0;
         send_q      <= 1'b0;
      end else begin
         state       <= state_next;
         baud_cnt    <= baud_next;
         bit_idx     <= bit_next;
         shreg       <= shreg_next;
         par_en      <= par_en_next;
         par_bit     <= par_bit_next;
         frame_count <= count_next;
         overrun     <= overrun_next;
         send_q      <= uio_in[0];
      end
   end

   // Parity is folded from the byte at latch time, so the shifter can consume the data freely.
   always_comb begin
      state_next   = state;
      baud_next    = bit_done ? 8'd0 : baud_cnt + 8'd1;
      bit_next     = bit_idx;
      shreg_next   = shreg;
      par_en_next  = par_en;
      par_bit_next = par_bit;
      count_next   = frame_count;
      overrun_next = overrun | (send_edge & (state != IDLE));
      case (state)
         IDLE: begin
            baud_next = 8'd0;
            if (send_edge) begin
               state_next   = START;
               shreg_next   = ui_in;
               par_en_next  = uio_in[1];
               par_bit_next = ^ui_in;
               bit_next     = 3'd0;
            end
         end
         START: begin
            if (bit_done) state_next = DATA;
         end
         DATA: begin
            if (bit_done) begin
               shreg_next = {1'b0, shreg[7:1]};
               bit_next   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = par_en ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_done) state_next = STOP;
         end
         STOP: begin
            if (bit_done) begin
               state_next = IDLE;
               count_next = frame_count + 7'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tx   = 1'b1;
      busy = (state != IDLE);
      case (state)
         START:   tx = 1'b0;
         DATA:    tx = shreg[0];
         PARITY:  tx = par_bit;
         default: tx = 1'b1;
      endcase
   end

   assign uo_out  = {overrun, frame_count};
   assign uio_out = {6'b000000, busy, tx};
   assign uio_oe  = 8'b0000_0011;

endmodule

// File: tb/tb_tt_um_sv_uart_tx.sv
// Bench for tt_um_sv_uart_tx at 4 clocks per bit: directed frames feed a scoreboard queue,
// and an independent monitor captures each busy window from the serial line and compares it.
module tb_tt_um_sv_uart_tx;

   typedef struct packed {
      logic [10:0] bits;
      logic [3:0]  nbits;
   } frame_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int     checks;
   int     failures;
   logic   const_bad;
   frame_t sb[$];

   tt_um_sv_uart_tx #(.CLKS_PER_BIT(4)) dut (
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe),
      .ena    (1'b1),
      .clk    (clk),
      .rst_n  (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference frame builder: bit i of .bits is the i-th bit on the line (start first).
   function automatic frame_t frame_model(input logic [7:0] data, input logic par);
      frame_t f;
      f.bits      = 11'd0;
      f.bits[8:1] = data;
      if (par) begin
         f.bits[9]  = ^data;
         f.bits[10] = 1'b1;
         f.nbits    = 4'd11;
      end else begin
         f.bits[9]  = 1'b1;
         f.nbits    = 4'd10;
      end
      return f;
   endfunction

   task automatic wait_idle(input int limit);
      int k;
      k = 0;
      while (uio_out[1] && k < limit) begin
         @(negedge clk);
         k++;
      end
      check_output("idle_reached", {31'd0, uio_out[1]}, 32'd0);
   endtask

   task automatic launch(input logic [7:0] data, input logic par, input frame_t exp);
      @(negedge clk);
      ui_in     = data;
      uio_in[1] = par;
      uio_in[0] = 1'b1;
      sb.push_back(exp);
      @(negedge clk);
      check_output("busy_start", {31'd0, uio_out[1]}, 32'd1);
      ui_in     = ~data;
      uio_in[1] = ~par;
      uio_in[0] = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [7:0] data, input logic par, input frame_t exp);
      launch(data, par, exp);
      wait_idle(80);
   endtask

   always @(negedge clk) begin
      if (uio_oe !== 8'h03 || uio_out[7:2] !== 6'd0) const_bad = 1'b1;
   end

   // Monitor: capture tx for every cycle busy is high, then score it against the oldest expectation.
   initial begin
      logic [63:0] samples;
      logic [10:0] got;
      frame_t      exp;
      int          n;
      int          errs;
      bit          aborted;
      forever begin
         @(negedge clk);
         if (rst_n && uio_out[1]) begin
            n       = 0;
            aborted = 0;
            samples = 64'd0;
            while (1) begin
               if (!rst_n) begin
                  aborted = 1;
                  break;
               end
               if (!uio_out[1]) break;
               if (n < 64) samples[n] = uio_out[0];
               n++;
               @(negedge clk);
            end
            if (!aborted) begin
               if (sb.size() == 0) begin
                  check_output("unexpected_frame", 32'(n), 32'd0);
               end else begin
                  exp  = sb.pop_front();
                  got  = 11'd0;
                  errs = 0;
                  for (int b = 0; b < 11; b++) begin
                     if (b < int'(exp.nbits)) got[b] = samples[b*4+1];
                  end
                  for (int i = 0; i < n && i < 44; i++) begin
                     if (samples[i] !== exp.bits[i/4]) errs++;
                  end
                  check_output("frame_len", 32'(n), 32'(exp.nbits) * 32'd4);
                  check_output("frame_bits", {21'd0, got}, {21'd0, exp.bits});
                  check_output("frame_sample_errs", 32'(errs), 32'd0);
               end
            end
         end
      end
   end

   initial begin
      checks    = 0;
      failures  = 0;
      const_bad = 1'b0;
      rst_n     = 1'b0;
      ui_in     = 8'h00;
      uio_in    = 8'h00;
      repeat (2) @(negedge clk);
      check_output("reset_uio_out", {24'd0, uio_out}, 32'h01);
      check_output("reset_uo_out", {24'd0, uo_out}, 32'h00);
      check_output("reset_uio_oe", {24'd0, uio_oe}, 32'h03);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 0xA5 no parity: 0,1,0,1,0,0,1,0,1,1
      apply_stimulus(8'hA5, 1'b0, '{bits: 11'h34A, nbits: 4'd10});
      check_output("count_after_a5", {24'd0, uo_out}, 32'h01);
      // 0x07 with parity: 0,1,1,1,0,0,0,0,0,1,1
      apply_stimulus(8'h07, 1'b1, '{bits: 11'h60E, nbits: 4'd11});
      check_output("count_after_07p", {24'd0, uo_out}, 32'h02);
      // 0xA5 with parity: parity bit 0
      apply_stimulus(8'hA5, 1'b1, '{bits: 11'h54A, nbits: 4'd11});
      check_output("count_after_a5p", {24'd0, uo_out}, 32'h03);

      // Second request edge mid-frame must be dropped and flag overrun.
      launch(8'h3C, 1'b0, '{bits: 11'h278, nbits: 4'd10});
      repeat (8) @(negedge clk);
      uio_in[0] = 1'b1;
      @(negedge clk);
      uio_in[0] = 1'b0;
      wait_idle(80);
      repeat (50) @(negedge clk);
      check_output("overrun_count", {24'd0, uo_out}, 32'h84);
      check_output("overrun_no_second", {31'd0, uio_out[1]}, 32'd0);

      // Held request gives one frame; a fresh rising edge gives the next.
      @(negedge clk);
      ui_in     = 8'h55;
      uio_in[1] = 1'b0;
      uio_in[0] = 1'b1;
      sb.push_back('{bits: 11'h2AA, nbits: 4'd10});
      repeat (100) @(negedge clk);
      check_output("hold_one_frame", {24'd0, uo_out}, 32'h85);
      check_output("hold_idle", {31'd0, uio_out[1]}, 32'd0);
      uio_in[0] = 1'b0;
      @(negedge clk);
      ui_in     = 8'h00;
      uio_in[0] = 1'b1;
      sb.push_back('{bits: 11'h200, nbits: 4'd10});
      @(negedge clk);
      check_output("rearm_busy", {31'd0, uio_out[1]}, 32'd1);
      uio_in[0] = 1'b0;
      wait_idle(80);
      check_output("rearm_count", {24'd0, uo_out}, 32'h86);

      // Reset during data bit 3 aborts immediately; a request still high restarts after release.
      @(negedge clk);
      ui_in     = 8'hF0;
      uio_in[1] = 1'b0;
      uio_in[0] = 1'b1;
      repeat (18) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("abort_uio_out", {24'd0, uio_out}, 32'h01);
      check_output("abort_uo_out", {24'd0, uo_out}, 32'h00);
      check_output("abort_uio_oe", {24'd0, uio_oe}, 32'h03);
      repeat (2) @(negedge clk);
      ui_in = 8'h81;
      sb.push_back('{bits: 11'h302, nbits: 4'd10});
      rst_n = 1'b1;
      @(negedge clk);
      check_output("restart_busy", {31'd0, uio_out[1]}, 32'd1);
      uio_in[0] = 1'b0;
      wait_idle(80);
      check_output("restart_count", {24'd0, uo_out}, 32'h01);

      // 128 back-to-back frames wrap the counter to zero.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_output("pre_wrap_uo_out", {24'd0, uo_out}, 32'h00);
      for (int i = 0; i < 128; i++) begin
         apply_stimulus(8'(i) ^ 8'h3C, i[0], frame_model(8'(i) ^ 8'h3C, i[0]));
         if (i == 126) check_output("count_127", {24'd0, uo_out}, 32'h7F);
      end
      check_output("wrap_uo_out", {24'd0, uo_out}, 32'h00);

      repeat (3) @(negedge clk);
      check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
      check_output("const_outputs", {31'd0, const_bad}, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tt_um_sv_uart_tx.md
TT_UM_SV_UART_TX -- requirements
Module: tt_um_sv_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set the clock cycles per serial bit (legal range 2..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; SHALL take effect immediately when low.
REQ-004 ena  input  1  design powered; SHALL be ignored.
REQ-005 ui_in  input  8  byte to transmit; SHALL be sampled only when a frame is accepted.
REQ-006 uio_in  input  8  [0]=send request (level); [1]=parity enable; [7:2] SHALL be ignored.
REQ-007 uio_out  output  8  [0]=tx serial line; [1]=busy; [7:2] SHALL be constant 0.
REQ-008 uio_oe  output  8  SHALL be constant 8'b0000_0011.
REQ-009 uo_out  output  8  {overrun, frame_count[6:0]}.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 send_q SHALL register uio_in[0] every cycle; a send edge is uio_in[0]=1 with send_q=0 at a clock edge.
REQ-012 A send edge in IDLE SHALL, at that same edge: enter START, latch ui_in into the shift register, latch uio_in[1] as parity-enable, drive tx=0 and busy=1.
REQ-013 Each of START, DATA bits, PARITY and STOP SHALL hold tx constant for exactly CLKS_PER_BIT cycles, timed by a baud counter reset at each bit boundary.
REQ-014 DATA SHALL send 8 bits LSB first, using a 3-bit bit index; after bit 7 go to PARITY if parity enabled, else STOP.
REQ-015 PARITY SHALL send even parity (XOR of the 8 latched data bits).
REQ-016 STOP SHALL drive tx=1; on its final cycle FSM SHALL return to IDLE, clear busy, and increment frame_count.
REQ-017 Frame length SHALL be 10*CLKS_PER_BIT cycles without parity, 11*CLKS_PER_BIT with parity.
REQ-018 frame_count SHALL be 7 bits and wrap 127->0.
REQ-019 A send edge in any state other than IDLE SHALL be dropped and set overrun; overrun SHALL be sticky until reset.
REQ-020 A send edge coinciding with the final STOP cycle SHALL count as not-IDLE (dropped, overrun set).
REQ-021 A request held high SHALL start exactly one frame; the next frame requires a new low->high transition.
REQ-022 ui_in and uio_in[1] changes during a frame SHALL not affect that frame.
REQ-023 In IDLE, tx SHALL be 1 and busy 0.

Reset
REQ-024 While rst_n=0: state=IDLE, tx=1, busy=0, overrun=0, frame_count=0, send_q=0, counters=0, shift register=0.
REQ-025 Reset asserted mid-frame SHALL abort it at once (tx=1, no count increment); after release, a request already high SHALL be treated as a send edge, since send_q is 0.
REQ-026 uio_oe and uio_out[7:2] SHALL hold their constant values during reset.

Verification (CLKS_PER_BIT=4)
REQ-027 Send 0xA5, parity off -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high 40 cycles; uo_out=0x01 afterwards.
REQ-028 Send 0x07, parity on -> tx = 0,1,1,1,0,0,0,0,0,1(parity),1, each bit 4 cycles; busy 44 cycles; 0xA5 with parity gives parity bit 0.
REQ-029 Second send edge 10 cycles into a frame -> frame unaffected, no second frame, uo_out[7]=1 permanently, count advances by 1 only.
REQ-030 Hold uio_in[0] high for 100 cycles -> exactly one frame; lower for 1 cycle and raise -> second frame starts, count=2.
REQ-031 Assert rst_n low during DATA bit 3 -> tx=1, busy=0, uo_out=0x00 immediately; no clock edge needed.
REQ-032 Send 128 frames back-to-back, each after busy drops -> uo_out=0x00 (wrap), overrun=0; uio_oe=0x03 throughout.
